neuron_feeder: RTL and testbench

- Upstream stage of the 4-input neuron; one instance drives one neuron IN bundle.
- Accepts signed 8-bit activations on a parallel valid/ready port and buffers them in a small FIFO.
- Serializes each word LSB-first onto the REQ/ACK/DATA bit-serial link the neuron consumes.
- Decouples producers (testbench, memory, or previous layer) from neuron timing.

---
 rtl/neuron_feeder_pkg.sv | 13 +
 rtl/neuron_feeder_if.sv | 30 +++
 rtl/neuron_feeder_fifo.sv | 52 +++++
 rtl/neuron_feeder.sv | 107 ++++++++++
 tb/tb_neuron_feeder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/neuron_feeder_pkg.sv
// Shared definitions for the bit-serial neuron link blocks.
// Frame length and word width are fixed by the link format.
package neuron_feeder_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

endpackage

// File: rtl/neuron_feeder_if.sv
// Parallel word input plus REQ/ACK/DATA serial link of one feeder.
// master = producer/neuron side, slave = feeder side.
interface neuron_feeder_if import neuron_feeder_pkg::*; ();

    logic              IN_VALID;
    logic              IN_READY;
    logic [WORD_W-1:0] IN_DATA;
    logic              OUT_REQ;
    logic              OUT_ACK;
    logic              OUT_DATA;

    modport master (
        output IN_VALID,
        output IN_DATA,
        output OUT_REQ,
        input  IN_READY,
        input  OUT_ACK,
        input  OUT_DATA
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        input  OUT_REQ,
        output IN_READY,
        output OUT_ACK,
        output OUT_DATA
    );

endinterface

// File: rtl/neuron_feeder_fifo.sv
// Synchronous DEPTH x WORD_W FIFO with occupancy counter.
// Requests are ignored when full (push) or empty (pop).
module neuron_feeder_fifo import neuron_feeder_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [AW:0]       level,
    output logic              full
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level != '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wptr] <= wdata;
    end

    // Pointers wrap naturally; the counter resolves full vs empty.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/neuron_feeder.sv
// FIFO-buffered LSB-first serializer feeding one neuron input link.
// FEEDER_REPLAY_EN: an empty FIFO replays the last popped word.
module neuron_feeder import neuron_feeder_pkg::*; #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            CLK,
    input  logic            RSTB,
    neuron_feeder_if.slave  link,
    output logic [AW:0]     LEVEL
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [WORD_W-1:0] sh, sh_n;
    logic              armed, armed_n;
    logic              ack, ack_n;
    logic              dat, dat_n;
    logic              pop;
    logic              full;
    logic [WORD_W-1:0] head;
    logic [WORD_W-1:0] word;
    logic              start;

    neuron_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RSTB  (RSTB),
        .push  (link.IN_VALID),
        .pop   (pop),
        .wdata (link.IN_DATA),
        .rdata (head),
        .level (LEVEL),
        .full  (full)
    );

    assign link.IN_READY = !full;
    assign link.OUT_ACK  = ack;
    assign link.OUT_DATA = dat;

`ifdef FEEDER_REPLAY_EN
    logic [WORD_W-1:0] last;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            last <= '0;
        else if (pop)
            last <= head;
    end

    assign word = (LEVEL != '0) ? head : last;
    assign start = (state == IDLE) && link.OUT_REQ && armed;
`else
    assign word = head;
    assign start = (state == IDLE) && link.OUT_REQ && armed
                   && (LEVEL != '0);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        armed_n = armed | !link.OUT_REQ;
        ack_n   = 1'b0;
        dat_n   = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    pop     = (LEVEL != '0);
                    state_n = SEND;
                    cnt_n   = CNT_W'(1);
                    ack_n   = 1'b1;
                    dat_n   = word[0];
                    sh_n    = {1'b0, word[WORD_W-1:1]};
                    armed_n = 1'b0;
                end
            end
            SEND: begin
                dat_n = sh[0];
                sh_n  = {1'b0, sh[WORD_W-1:1]};
                cnt_n = cnt + 1'b1;
                if (cnt == '1)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            armed <= 1'b1;
            ack   <= 1'b0;
            dat   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            armed <= armed_n;
            ack   <= ack_n;
            dat   <= dat_n;
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: framing, re-arm, FIFO order,
// full/pop interaction, async reset and empty-FIFO behaviour.
module tb_neuron_feeder;
    import neuron_feeder_pkg::*;

    logic       CLK;
    logic       RSTB;
    logic [2:0] LEVEL;
    int         checks;
    int         failures;
    int         nack;

    neuron_feeder_if bus ();

    neuron_feeder #(.DEPTH(4)) dut (
        .CLK   (CLK),
        .RSTB  (RSTB),
        .link  (bus.slave),
        .LEVEL (LEVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for ACK, then checks all 8 bits of the frame.
    task automatic frame(input string tag, input logic [7:0] w,
                         input bit tog);
        int n;
        n = 0;
        while (bus.OUT_ACK !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ack"}, 32'(bus.OUT_ACK), 32'd1);
        chk({tag, "_b0"}, 32'(bus.OUT_DATA), 32'(w[0]));
        if (tog)
            bus.OUT_REQ = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            if (tog && i == 1)
                bus.OUT_REQ = 1'b1;
            chk($sformatf("%s_ack%0d", tag, i), 32'(bus.OUT_ACK), 32'd0);
            chk($sformatf("%s_b%0d", tag, i), 32'(bus.OUT_DATA),
                32'(w[i]));
        end
    endtask

    task automatic push(input logic [7:0] w);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = w;
        step();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic count_acks(input int cycles);
        nack = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.OUT_ACK === 1'b1)
                nack++;
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        RSTB         = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'h00;
        bus.OUT_REQ  = 1'b0;
        step();
        step();
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_ready", 32'(bus.IN_READY), 32'd1);
        chk("rst_ack", 32'(bus.OUT_ACK), 32'd0);
        chk("rst_data", 32'(bus.OUT_DATA), 32'd0);
        RSTB = 1'b1;
        step();

        // Single word, latency and level change at frame start.
        bus.OUT_REQ = 1'b1;
        push(8'h35);
        chk("t1_level1", 32'(LEVEL), 32'd1);
        chk("t1_noack", 32'(bus.OUT_ACK), 32'd0);
        step();
        chk("t1_level0", 32'(LEVEL), 32'd0);
        frame("t1", 8'h35, 1'b0);
        step();
        chk("t1_idle_ack", 32'(bus.OUT_ACK), 32'd0);
        chk("t1_idle_data", 32'(bus.OUT_DATA), 32'd0);

        // Back-to-back words; re-arm via one-cycle REQ drop.
        bus.OUT_REQ = 1'b0;
        step();
        bus.OUT_REQ = 1'b1;
        push(8'h80);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'h7F;
        step();
        bus.IN_VALID = 1'b0;
        chk("t2_pushpop_level", 32'(LEVEL), 32'd1);
        frame("t2a", 8'h80, 1'b1);
        step();
        frame("t2b", 8'h7F, 1'b0);
        push(8'h11);
        count_acks(20);
        chk("t2_noarm_acks", 32'(nack), 32'd0);
        chk("t2_noarm_level", 32'(LEVEL), 32'd1);
        bus.OUT_REQ = 1'b0;
        step();
        bus.OUT_REQ = 1'b1;
        frame("t2c", 8'h11, 1'b0);

        // Fill with REQ low, drop a fifth push, drain in order.
        bus.OUT_REQ = 1'b0;
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        push(8'hD4);
        chk("t3_full_level", 32'(LEVEL), 32'd4);
        chk("t3_full_ready", 32'(bus.IN_READY), 32'd0);
        push(8'hE5);
        chk("t3_drop_level", 32'(LEVEL), 32'd4);
        bus.OUT_REQ = 1'b1;
        frame("t3a", 8'hA1, 1'b1);
        step();
        frame("t3b", 8'hB2, 1'b1);
        step();
        frame("t3c", 8'hC3, 1'b1);
        step();
        frame("t3d", 8'hD4, 1'b0);
        count_acks(10);
        chk("t3_drained_acks", 32'(nack), 32'd0);
        chk("t3_drained_level", 32'(LEVEL), 32'd0);

        // Full FIFO: pop at frame start blocks the same-edge push.
        bus.OUT_REQ = 1'b0;
        push(8'h0F);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        bus.OUT_REQ  = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 8'h05;
        step();
        chk("t4_pop_level", 32'(LEVEL), 32'd3);
        chk("t4_pop_ack", 32'(bus.OUT_ACK), 32'd1);
        chk("t4_pop_b0", 32'(bus.OUT_DATA), 32'd1);
        step();
        bus.IN_VALID = 1'b0;
        chk("t4_push_level", 32'(LEVEL), 32'd4);
        chk("t4_b1", 32'(bus.OUT_DATA), 32'd1);
        step();
        step();
        chk("t4_b3", 32'(bus.OUT_DATA), 32'd1);

        // Asynchronous reset in the middle of bit 3.
        #2 RSTB = 1'b0;
        #1;
        chk("t5_ack", 32'(bus.OUT_ACK), 32'd0);
        chk("t5_data", 32'(bus.OUT_DATA), 32'd0);
        chk("t5_level", 32'(LEVEL), 32'd0);
        chk("t5_ready", 32'(bus.IN_READY), 32'd1);
        @(negedge CLK);
        step();
        RSTB = 1'b1;
`ifndef FEEDER_REPLAY_EN
        count_acks(10);
        chk("t5_noframe", 32'(nack), 32'd0);
`endif

        // Empty FIFO after a frame: replay or stall.
        push(8'hF0);
        frame("t6a", 8'hF0, 1'b1);
        step();
`ifdef FEEDER_REPLAY_EN
        frame("t6r", 8'hF0, 1'b0);
        chk("t6r_level", 32'(LEVEL), 32'd0);
`else
        count_acks(50);
        chk("t6_stall", 32'(nack), 32'd0);
        chk("t6_level", 32'(LEVEL), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
